// File: rtl/riscv_main_ctrl.sv
// Main control decoder for the single-cycle RV32I datapath: opcode -> registered control strobes.
// Optional macro CTRL_ILLEGAL_OP_EN adds a registered illegal_op flag for undecoded opcodes.
module riscv_main_ctrl #(
    parameter int OPCODE_W = 7,
    parameter int ALUOP_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] Opcode,
    output logic                ALUSrc,
    output logic                MemtoReg,
    output logic                RegtoMem,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                Branch,
`ifdef CTRL_ILLEGAL_OP_EN
    output logic                illegal_op,
`endif
    output logic [ALUOP_W-1:0]  ALUOp
);

    localparam logic [OPCODE_W-1:0] OP_R_TYPE  = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_I_TYPE  = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LOAD    = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_S_TYPE  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_SB_TYPE = OPCODE_W'(7'b1100011);

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_CMP = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2'b10);
    localparam logic [ALUOP_W-1:0] ALU_I   = ALUOP_W'(2'b11);

    typedef struct packed {
        logic               alu_src;
        logic               mem_to_reg;
        logic               reg_to_mem;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    ctrl_t ctrl_d, ctrl_q;
    logic  illegal_d, illegal_q;

    // Opcode is only inspected under instr_valid, so an X opcode during a bubble never reaches the regs.
    always_comb begin
        ctrl_d    = '0;
        illegal_d = 1'b0;
        if (instr_valid) begin
            case (Opcode)
                OP_R_TYPE: begin
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.alu_op    = ALU_R;
                end
                OP_I_TYPE: begin
                    ctrl_d.alu_src   = 1'b1;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.alu_op    = ALU_I;
                end
                OP_LOAD: begin
                    ctrl_d.alu_src    = 1'b1;
                    ctrl_d.mem_to_reg = 1'b1;
                    ctrl_d.reg_write  = 1'b1;
                    ctrl_d.mem_read   = 1'b1;
                    ctrl_d.alu_op     = ALU_ADD;
                end
                OP_S_TYPE: begin
                    ctrl_d.alu_src    = 1'b1;
                    ctrl_d.reg_to_mem = 1'b1;
                    ctrl_d.mem_write  = 1'b1;
                    ctrl_d.alu_op     = ALU_ADD;
                end
                OP_SB_TYPE: begin
                    ctrl_d.branch = 1'b1;
                    ctrl_d.alu_op = ALU_CMP;
                end
                default: illegal_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign ALUSrc   = ctrl_q.alu_src;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign RegtoMem = ctrl_q.reg_to_mem;
    assign RegWrite = ctrl_q.reg_write;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign Branch   = ctrl_q.branch;
    assign ALUOp    = ctrl_q.alu_op;

`ifdef CTRL_ILLEGAL_OP_EN
    assign illegal_op = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_riscv_main_ctrl.sv
// Self-checking bench for riscv_main_ctrl: directed vector table, reset corners, random stress vs model.
module tb_riscv_main_ctrl;

`ifdef CTRL_ILLEGAL_OP_EN
    localparam logic ILLB = 1'b1;
`else
    localparam logic ILLB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic [6:0] Opcode = '0;
    logic       ALUSrc, MemtoReg, RegtoMem, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0] ALUOp;
    logic       ill_obs;

    int checks = 0;
    int errors = 0;

    riscv_main_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .Opcode(Opcode),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegtoMem(RegtoMem), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
`ifdef CTRL_ILLEGAL_OP_EN
        .illegal_op(ill_obs),
`endif
        .ALUOp(ALUOp)
    );

`ifndef CTRL_ILLEGAL_OP_EN
    assign ill_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    // {illegal, ALUSrc, MemtoReg, RegtoMem, RegWrite, MemRead, MemWrite, Branch, ALUOp}
    function automatic logic [9:0] observed();
        return {ill_obs, ALUSrc, MemtoReg, RegtoMem, RegWrite, MemRead, MemWrite, Branch, ALUOp};
    endfunction

    // Reference: lookup in a table of legal opcodes; anything absent is a no-op.
    function automatic logic [9:0] ref_dec(input logic v, input logic [6:0] op);
        logic [6:0] ops  [5];
        logic [8:0] rows [5];
        logic [9:0] r;
        ops[0] = 7'b0110011; rows[0] = 9'b0001000_10;
        ops[1] = 7'b0010011; rows[1] = 9'b1001000_11;
        ops[2] = 7'b0000011; rows[2] = 9'b1101100_00;
        ops[3] = 7'b0100011; rows[3] = 9'b1010010_00;
        ops[4] = 7'b1100011; rows[4] = 9'b0000001_01;
        if (!v) return '0;
        r = {ILLB, 9'b0};
        for (int k = 0; k < 5; k++)
            if (ops[k] == op) r = {1'b0, rows[k]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic chk_inv(input string name);
        logic ok;
        ok = !(MemRead && MemWrite) && !(MemWrite && RegWrite)
             && !(Branch && (RegWrite || MemWrite)) && !(MemtoReg && !MemRead);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s invariant got=%b exp=invariants hold", name, observed());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        logic       v;
        logic [6:0] op;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"sweep_r",     1'b1, 7'b0110011, 10'b0_0001000_10};
        vecs[1]  = '{"sweep_i",     1'b1, 7'b0010011, 10'b0_1001000_11};
        vecs[2]  = '{"sweep_s",     1'b1, 7'b0100011, 10'b0_1010010_00};
        vecs[3]  = '{"sweep_sb",    1'b1, 7'b1100011, 10'b0_0000001_01};
        vecs[4]  = '{"sweep_load",  1'b1, 7'b0000011, 10'b0_1101100_00};
        vecs[5]  = '{"bubble_load", 1'b0, 7'b0000011, 10'b0_0000000_00};
        vecs[6]  = '{"load_after",  1'b1, 7'b0000011, 10'b0_1101100_00};
        vecs[7]  = '{"illegal_jal", 1'b1, 7'b1101111, {ILLB, 9'b0}};
        vecs[8]  = '{"ill_clear",   1'b0, 7'b1101111, 10'b0_0000000_00};
        vecs[9]  = '{"b2b_s",       1'b1, 7'b0100011, 10'b0_1010010_00};
        vecs[10] = '{"b2b_sb",      1'b1, 7'b1100011, 10'b0_0000001_01};
        vecs[11] = '{"lui_noop",    1'b1, 7'b0110111, {ILLB, 9'b0}};

        // Reset held from time 0 with a valid R-type on the inputs.
        instr_valid = 1'b1;
        Opcode      = 7'b0110011;
        step();
        chk("reset_hold", observed(), '0);
        rst_n = 1'b1;
        step();
        chk("post_reset_r", observed(), 10'b0_0001000_10);

        // Mid-cycle asynchronous assertion clears outputs before any edge.
        #2 rst_n = 1'b0;
        #1 chk("async_reset", observed(), '0);
        #1 rst_n = 1'b1;
        step();
        chk("release_r", observed(), 10'b0_0001000_10);

        foreach (vecs[i]) begin
            instr_valid = vecs[i].v;
            Opcode      = vecs[i].op;
            step();
            chk(vecs[i].name, observed(), vecs[i].exp);
            chk_inv(vecs[i].name);
        end

        // Outputs hold between edges even if inputs change.
        instr_valid = 1'b1;
        Opcode      = 7'b0000011;
        step();
        instr_valid = 1'b0;
        #3 chk("hold_between_edges", observed(), 10'b0_1101100_00);
        step();

        for (int n = 0; n < 1000; n++) begin
            logic       v;
            logic [6:0] op;
            v  = ($urandom_range(0, 3) != 0);
            op = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: op = 7'b0110011;
                    1: op = 7'b0010011;
                    2: op = 7'b0000011;
                    3: op = 7'b0100011;
                    default: op = 7'b1100011;
                endcase
            end
            instr_valid = v;
            Opcode      = op;
            step();
            chk("random", observed(), ref_dec(v, op));
            chk_inv("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_main_ctrl.md
Name: riscv_main_ctrl

Overview:
- Main control decoder for the 32-bit single-cycle, 3-bus RISC-V datapath.
- Decodes the 7-bit instruction opcode into datapath control strobes and a 2-bit ALUOp for the downstream ALU controller.
- Outputs are registered: one clock of latency, a defined reset state, and bubble insertion when no valid instruction is present.

Parameters:
- OPCODE_W, 7, opcode width in bits; fixed at 7 for RV32I.
- ALUOP_W, 2, ALUOp width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  Opcode holds a valid instruction this cycle.
- Opcode  input  7  instruction bits [6:0].
- ALUSrc  output  1  1 = ALU operand B from immediate; 0 = from rs2.
- MemtoReg  output  1  1 = register write-back data from data memory.
- RegtoMem  output  1  1 = rs2 data routed to data-memory write bus.
- RegWrite  output  1  register file write enable.
- MemRead  output  1  data memory read enable.
- MemWrite  output  1  data memory write enable.
- Branch  output  1  conditional branch instruction.
- ALUOp  output  2  ALU class: 00 add (address calc), 01 compare/subtract (branch), 10 R-type funct decode, 11 I-type funct3 decode.

Behaviour:
- Reset: while rst_n = 0, every output is 0, including ALUOp = 00 and illegal_op if present. Reset is asynchronous on assertion; outputs update on clk edges only after rst_n deasserts.
- Latency: outputs reflect the Opcode/instr_valid sampled at the previous rising clk edge. Outputs are held between edges.
- Decode table (listed as ALUSrc, MemtoReg, RegtoMem, RegWrite, MemRead, MemWrite, Branch, ALUOp):
  - R_TYPE 0110011: 0,0,0,1,0,0,0,10
  - I_TYPE 0010011: 1,0,0,1,0,0,0,11
  - LOAD 0000011: 1,1,0,1,1,0,0,00
  - S_TYPE 0100011: 1,0,1,0,0,1,0,00
  - SB_TYPE 1100011: 0,0,0,0,0,0,1,01
- Any other opcode (including LUI, AUIPC, JAL, JALR, SYSTEM) decodes to all zeros: a no-op with no writes.
- instr_valid = 0: the next registered value is all zeros (bubble), regardless of Opcode.
- Invariants, which must hold in every cycle:
  - MemRead and MemWrite are never both 1.
  - MemWrite = 1 implies RegWrite = 0.
  - Branch = 1 implies RegWrite = 0 and MemWrite = 0.
  - MemtoReg = 1 only when MemRead = 1.
- Decode is a pure function of the sampled opcode. There is no internal state beyond the output registers, so back-to-back instructions of any type are decoded independently every cycle.
- X on Opcode while instr_valid = 0 must not propagate to the outputs.

Optional Feature:
- Macro: CTRL_ILLEGAL_OP_EN.
- Defined:
  - Adds output port illegal_op (1 bit), registered with the same one-cycle latency as the other outputs.
  - illegal_op = 1 for one cycle when instr_valid = 1 and the opcode is not one of the five decoded opcodes; otherwise 0.
  - Reset value is 0.
  - The other outputs still decode to all zeros for an illegal opcode.
- Not defined: the port is absent and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with Opcode = 0110011 and instr_valid = 1 -> all outputs go to 0 immediately (asynchronously), without waiting for a clk edge. Release reset -> after the next edge RegWrite = 1 and ALUOp = 10.
- Sweep with instr_valid = 1, one opcode per cycle: 0110011, 0010011, 0100011, 1100011, 0000011 -> one cycle later, outputs exactly match the decode table row for each opcode (e.g. S_TYPE gives ALUSrc = 1, RegtoMem = 1, MemWrite = 1, ALUOp = 00, others 0).
- Bubble: Opcode = 0000011 with instr_valid = 0 -> after the edge all outputs are 0. Raising instr_valid on the next cycle -> MemRead = 1 and MemtoReg = 1 one cycle later.
- Illegal opcode 1101111 with instr_valid = 1 -> all outputs 0; with CTRL_ILLEGAL_OP_EN defined, illegal_op = 1 for exactly one cycle.
- Back-to-back S_TYPE then SB_TYPE -> MemWrite = 1 for one cycle, then Branch = 1 with ALUOp = 01 and MemWrite = 0.
- Random 1000-cycle stress over all 128 opcodes with random instr_valid -> outputs match a reference model and all invariants hold in every cycle.
